// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths and write-back entry type
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - youngest-first forwarding match over queue entries and output stage
module wb_fwd_match #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [DEPTH-1:0]             ent_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_rd,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic                         out_valid,
  input  logic [ADDR_W-1:0]            out_rd,
  input  logic [DATA_W-1:0]            out_data,
  input  logic [ADDR_W-1:0]            rs,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  // Entries are ordered oldest (index 0) to youngest; later matches overwrite earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (out_valid && out_rd == rs) begin
      hit  = 1'b1;
      data = out_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_rd[i] == rs) begin
        hit  = 1'b1;
        data = ent_data[i];
      end
    end
    if (rs == '0) begin
      hit  = 1'b0;
      data = '0;
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - ordered two-producer write-back buffer driving one register-file write port
module writeback_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_rd,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     Reg_write,
  output logic [ADDR_W-1:0]        destination_reg,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        fwd_rs,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_rd_q [DEPTH];
  logic [ADDR_W-1:0] mem_rd_d [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, ld_slot;
  logic [CNT_W-1:0]  count_q, count_d, free;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] out_rd_q, out_rd_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              alu_push, ld_push, pop;

  logic [DEPTH-1:0]             ord_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ord_rd;
  logic [DEPTH-1:0][DATA_W-1:0] ord_data;

  // Space is judged on start-of-cycle occupancy, so a same-cycle pop never makes room.
  always_comb begin
    free      = CNT_W'(DEPTH) - count_q;
    alu_ready = reset && (free != '0);
    ld_ready  = reset && ((free >= CNT_W'(2)) ||
                          ((free != '0) && !(alu_valid && alu_rd != '0)));
    alu_push  = alu_valid && alu_ready && (alu_rd != '0);
    ld_push   = ld_valid && ld_ready && (ld_rd != '0);
    pop       = (count_q != '0);
  end

  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    head_d     = head_q;
    out_rd_d   = out_rd_q;
    out_data_d = out_data_q;
    rw_d       = pop;
    ld_slot    = tail_q + PTR_W'(alu_push);
    if (alu_push) begin
      mem_rd_d[tail_q]   = alu_rd;
      mem_data_d[tail_q] = alu_data;
    end
    if (ld_push) begin
      mem_rd_d[ld_slot]   = ld_rd;
      mem_data_d[ld_slot] = ld_data;
    end
    tail_d  = tail_q + PTR_W'(alu_push) + PTR_W'(ld_push);
    count_d = count_q + CNT_W'(alu_push) + CNT_W'(ld_push) - CNT_W'(pop);
    if (pop) begin
      head_d     = head_q + PTR_W'(1);
      out_rd_d   = mem_rd_q[head_q];
      out_data_d = mem_data_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rw_q       <= 1'b0;
      out_rd_q   <= '0;
      out_data_q <= '0;
    end else begin
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rw_q       <= rw_d;
      out_rd_q   <= out_rd_d;
      out_data_q <= out_data_d;
    end
  end

  // Present the queue oldest-first to the matcher, masking slots beyond the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ord_valid[i] = (CNT_W'(i) < count_q);
      ord_rd[i]    = mem_rd_q[head_q + PTR_W'(i)];
      ord_data[i]  = mem_data_q[head_q + PTR_W'(i)];
    end
  end

  wb_fwd_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd_match (
    .ent_valid (ord_valid),
    .ent_rd    (ord_rd),
    .ent_data  (ord_data),
    .out_valid (rw_q),
    .out_rd    (out_rd_q),
    .out_data  (out_data_q),
    .rs        (fwd_rs),
    .hit       (fwd_hit),
    .data      (fwd_data)
  );

  assign Reg_write       = rw_q;
  assign destination_reg = out_rd_q;
  assign write_data      = out_data_q;
  assign count           = count_q;
  assign empty           = (count_q == '0) && !rw_q;

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed self-checking bench for writeback_queue
module tb_writeback_queue;

  logic        clk;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        Reg_write;
  logic [4:0]  destination_reg;
  logic [31:0] write_data;
  logic [4:0]  fwd_rs;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;

  writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .ld_valid        (ld_valid),
    .ld_ready        (ld_ready),
    .ld_rd           (ld_rd),
    .ld_data         (ld_data),
    .Reg_write       (Reg_write),
    .destination_reg (destination_reg),
    .write_data      (write_data),
    .fwd_rs          (fwd_rs),
    .fwd_hit         (fwd_hit),
    .fwd_data        (fwd_data),
    .count           (count),
    .empty           (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Dual-producer stream: ALU pushes five entries, load competes for space.
  int t_av  [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int t_lv  [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
  int t_lrd [10] = '{20, 21, 22, 22, 22, 22, 0, 0, 0, 0};
  int t_ldt [10] = '{'h200, 'h201, 'h202, 'h202, 'h202, 'h202, 0, 0, 0, 0};
  int t_ar  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int t_lr  [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  int t_cnt [10] = '{2, 3, 3, 3, 3, 3, 2, 1, 0, 0};
  int t_rw  [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int t_wd  [10] = '{0, 'h100, 'h200, 'h101, 'h201, 'h102, 'h103, 'h104, 'h202, 0};
  int t_dr  [10] = '{0, 10, 20, 11, 21, 12, 13, 14, 22, 0};

  initial begin
    reset     = 1'b0;
    alu_valid = 1'b1;
    alu_rd    = 5'd7;
    alu_data  = 32'h99;
    ld_valid  = 1'b0;
    ld_rd     = 5'd0;
    ld_data   = 32'h0;
    fwd_rs    = 5'd0;

    // Reset held low for two cycles with a producer offering.
    tick();
    tick();
    check("rst_alu_ready", 64'(alu_ready), 64'd0);
    check("rst_ld_ready", 64'(ld_ready), 64'd0);
    check("rst_reg_write", 64'(Reg_write), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_dest", 64'(destination_reg), 64'd0);
    check("rst_wdata", 64'(write_data), 64'd0);

    reset     = 1'b1;
    alu_valid = 1'b0;
    #1;
    check("rel_alu_ready", 64'(alu_ready), 64'd1);
    check("rel_ld_ready", 64'(ld_ready), 64'd1);
    check("rel_empty", 64'(empty), 64'd1);

    // Single ALU result and its forwarding window.
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'h11;
    fwd_rs    = 5'd5;
    #1;
    check("a1_fwd_incoming_not_searched", 64'(fwd_hit), 64'd0);
    tick();
    alu_valid = 1'b0;
    #1;
    check("a1_count", 64'(count), 64'd1);
    check("a1_rw_e", 64'(Reg_write), 64'd0);
    check("a1_fwd_hit_q", 64'(fwd_hit), 64'd1);
    check("a1_fwd_data_q", 64'(fwd_data), 64'h11);
    tick();
    check("a1_rw", 64'(Reg_write), 64'd1);
    check("a1_dest", 64'(destination_reg), 64'd5);
    check("a1_wdata", 64'(write_data), 64'h11);
    check("a1_fwd_hit_out", 64'(fwd_hit), 64'd1);
    check("a1_fwd_data_out", 64'(fwd_data), 64'h11);
    check("a1_not_empty", 64'(empty), 64'd0);
    tick();
    check("a1_rw_done", 64'(Reg_write), 64'd0);
    check("a1_fwd_miss", 64'(fwd_hit), 64'd0);
    check("a1_fwd_miss_data", 64'(fwd_data), 64'd0);
    check("a1_dest_hold", 64'(destination_reg), 64'd5);
    check("a1_wdata_hold", 64'(write_data), 64'h11);
    check("a1_empty", 64'(empty), 64'd1);

    // Same-cycle ALU and load to the same register.
    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    alu_data  = 32'hA;
    ld_valid  = 1'b1;
    ld_rd     = 5'd3;
    ld_data   = 32'hB;
    fwd_rs    = 5'd3;
    #1;
    check("dual_ld_ready", 64'(ld_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    #1;
    check("dual_count", 64'(count), 64'd2);
    check("dual_fwd_young", 64'(fwd_data), 64'hB);
    tick();
    check("dual_w1", 64'(write_data), 64'hA);
    check("dual_w1_rw", 64'(Reg_write), 64'd1);
    check("dual_fwd_young2", 64'(fwd_data), 64'hB);
    tick();
    check("dual_w2", 64'(write_data), 64'hB);
    check("dual_w2_rw", 64'(Reg_write), 64'd1);
    check("dual_fwd_out", 64'(fwd_data), 64'hB);
    tick();
    check("dual_idle", 64'(Reg_write), 64'd0);

    // Sustained traffic across pointer wrap; ld_ready drops at free=1 with ALU active.
    fwd_rs = 5'd0;
    for (int i = 0; i < 10; i++) begin
      alu_valid = (t_av[i] != 0);
      alu_rd    = 5'(10 + i);
      alu_data  = 32'(32'h100 + i);
      ld_valid  = (t_lv[i] != 0);
      ld_rd     = 5'(t_lrd[i]);
      ld_data   = 32'(t_ldt[i]);
      #1;
      check($sformatf("str%0d_alu_ready", i), 64'(alu_ready), 64'(t_ar[i]));
      check($sformatf("str%0d_ld_ready", i), 64'(ld_ready), 64'(t_lr[i]));
      tick();
      check($sformatf("str%0d_count", i), 64'(count), 64'(t_cnt[i]));
      check($sformatf("str%0d_rw", i), 64'(Reg_write), 64'(t_rw[i]));
      if (t_rw[i] != 0) begin
        check($sformatf("str%0d_wdata", i), 64'(write_data), 64'(t_wd[i]));
        check($sformatf("str%0d_dest", i), 64'(destination_reg), 64'(t_dr[i]));
      end
    end
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    #1;
    check("str_empty", 64'(empty), 64'd1);

    // Writes to x0 complete the handshake but are dropped.
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'hDEAD;
    fwd_rs    = 5'd0;
    #1;
    check("x0_alu_ready", 64'(alu_ready), 64'd1);
    check("x0_fwd_hit", 64'(fwd_hit), 64'd0);
    tick();
    alu_valid = 1'b0;
    #1;
    check("x0_count", 64'(count), 64'd0);
    check("x0_rw_a", 64'(Reg_write), 64'd0);
    tick();
    check("x0_rw_b", 64'(Reg_write), 64'd0);
    check("x0_fwd_hit_after", 64'(fwd_hit), 64'd0);

    // Reset with three writes pending discards them all.
    alu_valid = 1'b1;
    alu_rd    = 5'd1;
    alu_data  = 32'h1;
    ld_valid  = 1'b1;
    ld_rd     = 5'd2;
    ld_data   = 32'h2;
    tick();
    ld_valid  = 1'b0;
    alu_rd    = 5'd3;
    alu_data  = 32'h3;
    tick();
    alu_valid = 1'b0;
    fwd_rs    = 5'd3;
    #1;
    check("pre_rst_count", 64'(count), 64'd2);
    check("pre_rst_rw", 64'(Reg_write), 64'd1);
    check("pre_rst_fwd", 64'(fwd_hit), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_rw", 64'(Reg_write), 64'd0);
    check("mid_rst_wdata", 64'(write_data), 64'd0);
    check("mid_rst_fwd", 64'(fwd_hit), 64'd0);
    tick();
    check("post_rst_rw1", 64'(Reg_write), 64'd0);
    tick();
    check("post_rst_rw2", 64'(Reg_write), 64'd0);
    check("post_rst_empty", 64'(empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers register-file write-back results from the ALU path and the multi-cycle load path and drives the register file's single write port at one write per cycle. It sits between the execute/memory stages and the register file, enforcing program order between simultaneous producers. It also exposes a forwarding lookup so operand reads never see stale values while writes are pending.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- DATA_W, 32, result width
- ADDR_W, 5, register index width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted when alu_valid & alu_ready
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted when ld_valid & ld_ready
- ld_rd  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load result
- Reg_write  out  1  register-file write enable, registered
- destination_reg  out  ADDR_W  write index, registered
- write_data  out  DATA_W  write value, registered
- fwd_rs  in  ADDR_W  forwarding query index
- fwd_hit  out  1  pending write to fwd_rs exists, combinational
- fwd_data  out  DATA_W  youngest pending value for fwd_rs, combinational
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0 and Reg_write == 0

## Operation
- Circular buffer of {rd, data} entries with head/tail pointers wrapping modulo DEPTH; count tracks occupancy 0..DEPTH.
- free = DEPTH − count, sampled at cycle start; a pop in the same cycle does not create space for a same-cycle push.
- alu_ready = free ≥ 1.
- ld_ready = (free ≥ 2) or (free ≥ 1 and not (alu_valid and alu_rd ≠ 0)).
- Both producers accepted in the same cycle: ALU entry is enqueued first and is therefore older; load entry follows.
- rd = 0 transfers complete normally when ready is high but are not enqueued and never assert Reg_write.
- Drain: every cycle with count > 0, pop the head into the output registers (Reg_write=1, destination_reg, write_data). With count = 0, Reg_write=0; destination_reg and write_data hold their last values.
- Forwarding: fwd_hit=1 iff fwd_rs ≠ 0 and fwd_rs matches a valid queue entry or the output stage (Reg_write=1). fwd_data comes from the youngest match; the output stage is oldest. Same-cycle incoming producer data is not searched. On a miss, fwd_data=0.
- While reset is low: alu_ready=ld_ready=0, count=0, pointers=0, Reg_write=0, destination_reg=0, write_data=0. Reset mid-operation discards all pending entries without issuing writes.

## Timing
- Accept at edge E → entry at head after E (if queue was empty) → popped at E+1 → Reg_write high in cycle E+1..E+2 → register file writes at E+2.
- Throughput: one write per cycle sustained; up to two enqueues per cycle.
- Full queue: both readies low; one pop frees space visible from the next cycle.
- fwd_hit/fwd_data are purely combinational from state and fwd_rs; no cycle of latency.
- First cycle after reset release: readies high, empty=1.

## Structure
- Shared package riscv_pkg: XLEN=32, REG_ADDR_W=5, typedef wb_entry_t {rd, data}.
- One sub-module: wb_fwd_match — youngest-first priority match over queue entries plus the output stage, returning hit/data. Storage, pointers, and handshake logic remain in writeback_queue.

## Test plan
- Reset low for 2 cycles with alu_valid=1 → readies 0, no Reg_write. After release → alu_ready=1, empty=1.
- ALU {rd=5, 0x11} at edge E → Reg_write=1, destination_reg=5, write_data=0x11 after E+1; fwd_rs=5 → hit with 0x11 from E until the write completes.
- Same cycle: ALU {rd=3, 0xA} and load {rd=3, 0xB} → writes in order 0xA then 0xB; fwd_data=0xB while both are pending.
- Five ALU pushes with no stall (DEPTH=4) → queue never holds more than 4. Verify alu_ready drops at free=0 or ld_ready drops at free=1 with ALU active. No entry lost, and write order matches accept order across pointer wrap.
- alu_rd=0 with data 0xDEAD → accepted, count unchanged, no Reg_write. fwd_rs=0 → fwd_hit=0.
- Three entries pending, reset asserted for one cycle → count=0, Reg_write=0 next cycle, no pending writes issued afterwards.
